// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared Kyber constants, operand types and requester IDs
package kyber_pkg;

  localparam int WIDTH   = 16;
  localparam int NREQ    = 2;
  localparam int KYBER_Q = 3329;
  localparam int QINV    = -3327;
  localparam int MONT    = -1044;

  typedef logic signed [WIDTH-1:0]   int16_t;
  typedef logic signed [2*WIDTH-1:0] int32_t;
  typedef logic                      req_id_t;

  // 16-bit forms of the constants used directly in the datapath
  localparam int16_t QINV16 = int16_t'(QINV);
  localparam int16_t Q16    = int16_t'(KYBER_Q);

  // One request entering the shared multiplier
  typedef struct packed {
    req_id_t tag;
    int16_t  a;
    int16_t  b;
  } mm_req_t;

  // Response-valid vector addressed to a single requester
  function automatic logic [NREQ-1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mont_mul_arb_if.sv
// rtl/mont_mul_arb_if.sv - request/response bundle between requesters and mont_mul_arb
interface mont_mul_arb_if;
  import kyber_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  int16_t                rsp_data;

  // Requester side: drives operands and response accept
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mont_mul_pipe.sv
// rtl/mont_mul_pipe.sv - pipelined Montgomery multiply-reduce a*b*2^-16 mod q; MONT_MUL_ARB_CANON_EN adds a canonicalising S4
module mont_mul_pipe
  import kyber_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    in_valid,
  input  mm_req_t in_req,
  output logic    out_valid,
  output req_id_t out_tag,
  output int16_t  out_data,
  output logic    busy
);

  logic    s1_valid_q, s1_valid_d;
  req_id_t s1_tag_q,   s1_tag_d;
  int32_t  s1_p_q,     s1_p_d;

  logic    s2_valid_q, s2_valid_d;
  req_id_t s2_tag_q,   s2_tag_d;
  int32_t  s2_p_q,     s2_p_d;
  int16_t  s2_t_q,     s2_t_d;

  logic    s3_valid_q, s3_valid_d;
  req_id_t s3_tag_q,   s3_tag_d;
  int16_t  s3_r_q,     s3_r_d;

`ifdef MONT_MUL_ARB_CANON_EN
  logic    s4_valid_q, s4_valid_d;
  req_id_t s4_tag_q,   s4_tag_d;
  int16_t  s4_r_q,     s4_r_d;
`endif

  // Next-stage values: hold everything when disabled, otherwise shift one stage
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_tag_d   = s1_tag_q;
    s1_p_d     = s1_p_q;
    s2_valid_d = s2_valid_q;
    s2_tag_d   = s2_tag_q;
    s2_p_d     = s2_p_q;
    s2_t_d     = s2_t_q;
    s3_valid_d = s3_valid_q;
    s3_tag_d   = s3_tag_q;
    s3_r_d     = s3_r_q;
`ifdef MONT_MUL_ARB_CANON_EN
    s4_valid_d = s4_valid_q;
    s4_tag_d   = s4_tag_q;
    s4_r_d     = s4_r_q;
`endif
    if (en) begin
      // S1: full signed product
      s1_valid_d = in_valid;
      s1_tag_d   = in_req.tag;
      s1_p_d     = int32_t'(in_req.a) * int32_t'(in_req.b);
      // S2: t = p * q^-1 mod 2^16, only the low half matters
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
      s2_p_d     = s1_p_q;
      s2_t_d     = int16_t'(s1_p_q[WIDTH-1:0] * QINV16);
      // S3: p - t*q has zero low half; 33 bits keep the sign of the full difference
      s3_valid_d = s2_valid_q;
      s3_tag_d   = s2_tag_q;
      s3_r_d     = int16_t'((33'(s2_p_q) - 33'(s2_t_q) * 33'(KYBER_Q)) >>> 16);
`ifdef MONT_MUL_ARB_CANON_EN
      // S4: fold (-q, 0) into [0, q)
      s4_valid_d = s3_valid_q;
      s4_tag_d   = s3_tag_q;
      s4_r_d     = s3_r_q[WIDTH-1] ? s3_r_q + Q16 : s3_r_q;
`endif
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= 1'b0;
      s1_p_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_tag_q   <= 1'b0;
      s2_p_q     <= '0;
      s2_t_q     <= '0;
      s3_valid_q <= 1'b0;
      s3_tag_q   <= 1'b0;
      s3_r_q     <= '0;
`ifdef MONT_MUL_ARB_CANON_EN
      s4_valid_q <= 1'b0;
      s4_tag_q   <= 1'b0;
      s4_r_q     <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_p_q     <= s1_p_d;
      s2_valid_q <= s2_valid_d;
      s2_tag_q   <= s2_tag_d;
      s2_p_q     <= s2_p_d;
      s2_t_q     <= s2_t_d;
      s3_valid_q <= s3_valid_d;
      s3_tag_q   <= s3_tag_d;
      s3_r_q     <= s3_r_d;
`ifdef MONT_MUL_ARB_CANON_EN
      s4_valid_q <= s4_valid_d;
      s4_tag_q   <= s4_tag_d;
      s4_r_q     <= s4_r_d;
`endif
    end
  end

`ifdef MONT_MUL_ARB_CANON_EN
  assign out_valid = s4_valid_q;
  assign out_tag   = s4_tag_q;
  assign out_data  = s4_r_q;
  assign busy      = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q;
`else
  assign out_valid = s3_valid_q;
  assign out_tag   = s3_tag_q;
  assign out_data  = s3_r_q;
  assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;
`endif

endmodule

// File: rtl/mont_mul_arb.sv
// rtl/mont_mul_arb.sv - round-robin sharing of one Montgomery multiplier between two requesters (MONT_MUL_ARB_CANON_EN: canonical results)
module mont_mul_arb
  import kyber_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mont_mul_arb_if.slave  bus,
  output logic           busy
);

  req_id_t         last_q, last_d;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic            stall;
  logic            accept;
  req_id_t         sel;
  mm_req_t         sel_req;

  logic            head_valid;
  req_id_t         head_tag;
  int16_t          head_data;

  // Grant, head-of-line stall and operand selection for the winning requester
  always_comb begin
    grant = bus.req_valid;
    if (&bus.req_valid) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    stall       = head_valid & ~bus.rsp_ready[head_tag];
    ready       = stall ? '0 : grant;
    accept      = |(bus.req_valid & ready);
    sel         = grant[1];
    sel_req.tag = sel;
    sel_req.a   = sel ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    sel_req.b   = sel ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    last_d      = accept ? sel : last_q;
  end

  // Round-robin pointer; starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  mont_mul_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (~stall),
    .in_valid  (accept),
    .in_req    (sel_req),
    .out_valid (head_valid),
    .out_tag   (head_tag),
    .out_data  (head_data),
    .busy      (busy)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = head_valid ? id_onehot(head_tag) : '0;
  assign bus.rsp_data  = head_data;

endmodule

// File: tb/tb_mont_mul_arb.sv
// tb/tb_mont_mul_arb.sv - self-checking bench for mont_mul_arb (both MONT_MUL_ARB_CANON_EN builds)
module tb_mont_mul_arb;
  import kyber_pkg::*;

`ifdef MONT_MUL_ARB_CANON_EN
  localparam int LAT     = 4;
  localparam int NEG_EXP = 3160;
`else
  localparam int LAT     = 3;
  localparam int NEG_EXP = -169;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  mont_mul_arb_if bus();

  mont_mul_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: a*b*2^-16 mod q by Montgomery's definition on wide integers
  function automatic int mont_ref(input int a, input int b);
    longint p, pl, x;
    int t, r;
    p  = longint'(a) * longint'(b);
    pl = p & 64'h0000_0000_0000_FFFF;
    x  = pl * -3327;
    t  = int'($signed(x[15:0]));
    r  = int'((p - longint'(t) * 3329) / 65536);
`ifdef MONT_MUL_ARB_CANON_EN
    if (r < 0) r = r + 3329;
`endif
    return r;
  endfunction

  // Behavioural model: a LAT-deep queue of (valid, tag, value) plus pointer
  bit mv [LAT];
  bit mt [LAT];
  int md [LAT];
  bit m_last = 1'b1;

  typedef struct {
    bit tag;
    int data;
  } obs_t;
  obs_t obs[$];

  function automatic logic [1:0] m_grant();
    if (bus.req_valid == 2'b11) return m_last ? 2'b01 : 2'b10;
    return bus.req_valid;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < LAT; i++) begin
      mv[i] = 1'b0;
      mt[i] = 1'b0;
      md[i] = 0;
    end
    m_last = 1'b1;
  endtask

  bit         hv, ht, m_stall, m_any;
  logic [1:0] exp_ready, g;

  always begin
    @(negedge clk);
    if (!rst_n) m_clear();
    hv      = mv[LAT-1];
    ht      = mt[LAT-1];
    m_stall = hv && !bus.rsp_ready[ht];
    exp_ready = m_stall ? 2'b00 : m_grant();
    m_any = 1'b0;
    for (int i = 0; i < LAT; i++) m_any |= mv[i];
    chk("mdl_req_ready", bus.req_ready, exp_ready);
    chk("mdl_rsp_valid", bus.rsp_valid, hv ? (2'b01 << ht) : 2'b00);
    chk("mdl_busy", busy, m_any);
    if (hv) chk("mdl_rsp_data", bus.rsp_data, md[LAT-1]);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) obs.push_back('{tag: i[0], data: int'(bus.rsp_data)});
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_clear();
    end else if (!m_stall) begin
      g = m_grant();
      for (int i = LAT-1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mt[i] = mt[i-1];
        md[i] = md[i-1];
      end
      mv[0] = |g;
      mt[0] = g[1];
      md[0] = g[1] ? mont_ref(int'($signed(bus.req_a[31:16])), int'($signed(bus.req_b[31:16])))
                   : mont_ref(int'($signed(bus.req_a[15:0])), int'($signed(bus.req_b[15:0])));
      if (|g) m_last = g[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_one(input int id, input int a, input int b, input int exp_data, input string name);
    int cnt;
    bus.req_a = '0;
    bus.req_b = '0;
    if (id == 0) begin
      bus.req_a[15:0] = 16'(a);
      bus.req_b[15:0] = 16'(b);
      bus.req_valid   = 2'b01;
    end else begin
      bus.req_a[31:16] = 16'(a);
      bus.req_b[31:16] = 16'(b);
      bus.req_valid    = 2'b10;
    end
    tick();
    bus.req_valid = 2'b00;
    cnt = 1;
    while (bus.rsp_valid == 2'b00 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk({name, "_latency"}, cnt, LAT);
    chk({name, "_rsp_valid"}, bus.rsp_valid, (id == 0) ? 1 : 2);
    chk({name, "_rsp_data"}, bus.rsp_data, exp_data);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int cnt;
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 2'b11;
    rst_n         = 1'b0;

    // Reset state
    tick();
    bus.req_valid = 2'b10;
    #1;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_ready", bus.req_ready, 2);
    bus.req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();

    // Pin the reference against hand-computed values
    chk("ref_1x1", mont_ref(1, 1), 169);
    chk("ref_qx1", mont_ref(3329, 1), 0);
    chk("ref_mont", mont_ref(-1044, 1000), 1000);
    chk("ref_neg", mont_ref(-1, 1), NEG_EXP);
    chk("ref_2x1", mont_ref(2, 1), 338);
    chk("ref_5x1", mont_ref(5, 1), 845);

    // Single transactions
    send_one(0, 1, 1, 169, "one");
    send_one(1, 3329, 1, 0, "q");
    send_one(0, -1044, 1000, 1000, "mont");
    send_one(0, -1, 1, NEG_EXP, "neg");

    // Both requesters valid for 4 cycles right after reset
    do_reset();
    obs.delete();
    bus.req_a = {16'd5, 16'd2};
    bus.req_b = {16'd1, 16'd1};
    bus.req_valid = 2'b11;
    repeat (4) tick();
    bus.req_valid = 2'b00;
    cnt = 0;
    while (obs.size() < 4 && cnt < 30) begin
      tick();
      cnt++;
    end
    chk("rr_count", obs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs.size()) begin
        chk("rr_tag", obs[i].tag, i % 2);
        chk("rr_data", obs[i].data, (i % 2 == 1) ? 845 : 338);
      end
    end

    // Head-of-line stall on requester 0
    bus.rsp_ready = 2'b10;
    bus.req_a = {16'd0, 16'd1};
    bus.req_b = {16'd0, 16'd1};
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    cnt = 0;
    while (bus.rsp_valid == 2'b00 && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("stall_head_seen", bus.rsp_valid, 1);
    obs.delete();
    bus.req_a = {16'd5, 16'd2};
    bus.req_b = {16'd1, 16'd1};
    bus.req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      chk("stall_data", bus.rsp_data, 169);
      chk("stall_rsp_valid", bus.rsp_valid, 1);
      chk("stall_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b00;
    repeat (10) tick();
    chk("stall_release_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("stall_release_tag", obs[0].tag, 0);
      chk("stall_release_data", obs[0].data, 169);
    end

    // Reset with three operations in flight
    obs.delete();
    bus.req_a = {16'd0, 16'd7};
    bus.req_b = {16'd0, 16'd3};
    bus.req_valid = 2'b01;
    repeat (3) tick();
    bus.req_valid = 2'b00;
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("midrst_no_stale", obs.size(), 0);
    chk("midrst_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_mul_arb.md
Name: mont_mul_arb

Overview:
- Shares one pipelined Montgomery multiply-reduce datapath, computing a*b*2^-16 mod q, between two requesters:
  - requester 0: NTT butterfly unit
  - requester 1: pointwise polyvec multiplier
- Round-robin arbitration with valid/ready on both request and response sides.
- Each result is tagged with the requester ID and routed back to the requester that issued it.

Parameters:
- KYBER_Q, 3329, modulus q
- QINV, -3327, q^-1 mod 2^16 (signed 16-bit)
- WIDTH, 16, operand/result width (int16)
- NREQ, 2, number of requesters (fixed at 2; other values unsupported)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester operand valid
- req_ready  out  2  per-requester accept; transfer when valid&ready
- req_a  in  2*16  signed operand a; requester i at bits [16i+15:16i]
- req_b  in  2*16  signed operand b, same packing
- rsp_valid  out  2  one-hot result valid, addressed to the requester
- rsp_ready  in  2  per-requester result accept
- rsp_data  out  16  signed result, shared by both requesters
- busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Reset (async, rst_n low):
  - all stage valid bits = 0; rsp_valid = 0; rsp_data = 0; busy = 0
  - round-robin pointer last = 1, so requester 0 wins the first tie
- Arbitration is combinational from req_valid and last:
  - only one valid: grant it
  - both valid: grant the requester != last
  - req_ready[i] = grant[i] & ~stall
  - last updates to i only on an accepted transfer
- Pipeline stages (base latency 3 cycles, accepted request to rsp_valid):
  - S1: p = a*b, 32-bit signed; register p, tag, valid
  - S2: t = signed low 16 bits of (p[15:0]*QINV); register p, t, tag, valid
  - S3: r = (p - t*KYBER_Q) >>> 16, arithmetic shift; register r[15:0] to rsp_data, tag, valid
- S3 arithmetic: p - t*q must be evaluated in at least 33 signed bits. Its low 16 bits are always 0.
- Result range: -q < r < q. r ≡ a*b*2^-16 (mod q).
- Outputs: rsp_valid[tag] = s3_valid; the other bit is 0.
- Stall: stall = s3_valid & ~rsp_ready[s3_tag]. A stall freezes every stage and blocks acceptance.
- While stalled, rsp_data, rsp_valid and the tag hold stable.
- No stall: all stages advance every cycle; a bubble enters S1 when nothing is accepted.
- Throughput: 1 op/cycle with no stalls; alternates 0,1,0,1 while both requesters are continuously valid.
- Stall interactions:
  - A stall on requester 0's response also blocks requester 1 (head-of-line blocking, accepted by design).
  - While stalled, the arbiter pointer does not move.
- Simultaneous response handshake and new request in the same cycle: both occur; the pipeline shifts.
- Reset mid-operation discards all in-flight entries; no response is emitted.
- busy = s1_valid | s2_valid | s3_valid (plus S4 when the optional stage exists).

Optional Feature:
- Macro MONT_MUL_ARB_CANON_EN.
- Defined:
  - adds an S4 stage: if r < 0 then r += q
  - rsp_data is canonical in [0, q-1]
  - latency 4
  - stall rule applies to S4 as the head stage
- Undefined: 3-stage pipeline; centered result in (-q, q).

Decomposition:
- Shared package kyber_pkg:
  - KYBER_Q, QINV, MONT (-1044)
  - int16/int32 typedefs
  - requester-ID typedef (1 bit)
- Sub-module mont_mul_pipe: stages S1..S3/S4 with a global enable and tag pass-through.
- Top level keeps the arbiter, pointer, stall logic and response demux.

Test Plan:
- Requester 0 sends a=1, b=1; rsp_ready=2'b11 -> rsp_valid=2'b01 three cycles later, rsp_data=169 (2^-16 mod q).
- Requester 1 sends a=3329, b=1 -> rsp_valid=2'b10, rsp_data=0. Requester 0 sends a=-1044, b=1000 -> rsp_data=1000.
- Both valid for 4 cycles from reset -> grant order 0,1,0,1; responses return in the same order with the correct tags.
- rsp_ready[0]=0 for 5 cycles while requester 0 has a result at the head -> rsp_data stable; req_ready=2'b00; no loss or duplicate after release.
- Assert rst_n low with 3 ops in flight -> rsp_valid=0 and busy=0 immediately; no stale responses after reset release.
- With MONT_MUL_ARB_CANON_EN: a=-1, b=1 -> rsp_data=3160 after 4 cycles. Undefined: same stimulus gives rsp_data=-169 after 3 cycles.
